// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported, variable-latency memory between the fetch port and the
//           data port; data wins unless fetch has waited MAX_DSTREAK data grants.
// Latency : gnt in the IDLE cycle, mem_req from the next cycle, done one cycle after mem_ack.
// Backpr. : one access in flight; gnt stays low while busy, so requesters hold req until gnt.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt      fetch request, combinational grant
//   if_done/if_err/if_rdata       fetch completion pulse, timeout flag, read data
//   d_req/d_we/d_addr/d_wdata     data request (load/store), d_gnt combinational grant
//   d_done/d_err/d_rdata          data completion pulse, timeout flag, load data (0 for stores)
//   mem_req/mem_we/mem_addr/...   registered memory command
//   mem_ack/mem_rdata             memory completion pulse and read data
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic              if_err,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic              d_err,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam int DS_W = $clog2(MAX_DSTREAK + 1);
  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [DS_W-1:0] DS_MAX  = DS_W'(MAX_DSTREAK);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]      state;
  logic [DS_W-1:0] dstreak;   // data grants issued while fetch was waiting
  logic [WD_W-1:0] wd_cnt;    // busy cycles elapsed in the current access

  // Data has priority until fetch has been passed over MAX_DSTREAK times in a row.
  always_comb begin
    d_gnt  = 1'b0;
    if_gnt = 1'b0;
    if (!rst && state == IDLE) begin
      if (d_req && (!if_req || dstreak < DS_MAX)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dstreak   <= '0;
      wd_cnt    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_gnt) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            wd_cnt    <= '0;
            state     <= BUSY_D;
          end else if (if_gnt) begin
            // Fetch never writes; mem_wdata keeps its previous value.
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            wd_cnt   <= '0;
            state    <= BUSY_I;
          end

          if (if_gnt || !if_req) begin
            dstreak <= '0;
          end else if (d_gnt && dstreak < DS_MAX) begin
            dstreak <= dstreak + DS_W'(1);
          end
        end

        BUSY_I, BUSY_D: begin
          // An ack arriving on the last watchdog cycle still completes normally.
          if (mem_ack || wd_cnt == WD_LAST) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (state == BUSY_D) begin
              d_done  <= 1'b1;
              d_err   <= !mem_ack;
              d_rdata <= (mem_ack && !mem_we) ? mem_rdata : '0;
            end else begin
              if_done  <= 1'b1;
              if_err   <= !mem_ack;
              if_rdata <= mem_ack ? mem_rdata : '0;
            end
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end

        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MAX_DSTREAK = 4;
  localparam int TIMEOUT     = 16;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic              d_err;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DSTREAK(MAX_DSTREAK), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_done(if_done), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, observed hang, expected $finish");
    $fatal(1, "global timeout");
  end

  int n_asrt = 0;
  int n_fail = 0;

  // Memory model: acks once mem_req has been high for ack_lat cycles, unless ack_never.
  int          busy_cnt   = 0;
  int          ack_lat    = 1;
  logic        ack_never  = 1'b0;
  logic        inject_ack = 1'b0;
  logic [31:0] ack_data   = '0;

  // Reference state derived from the arbitration rules.
  int          m_streak   = 0;
  logic [31:0] m_wdata    = '0;
  logic [31:0] m_if_rdata = '0;
  logic [31:0] m_d_rdata  = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_req === 1'b1) busy_cnt++;
    else busy_cnt = 0;
    mem_ack    = inject_ack || (mem_req === 1'b1 && !ack_never && busy_cnt == ack_lat);
    mem_rdata  = mem_ack ? ack_data : $urandom;
    inject_ack = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mem_req"},   mem_req,   0);
    chk({tag, "_mem_we"},    mem_we,    0);
    chk({tag, "_mem_addr"},  mem_addr,  0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_done"},      {if_done, d_done}, 0);
    chk({tag, "_err"},       {if_err, d_err},   0);
    chk({tag, "_if_rdata"},  if_rdata,  0);
    chk({tag, "_d_rdata"},   d_rdata,   0);
  endtask

  // Presents requests in an IDLE cycle and follows the resulting access to its done cycle.
  // who: 0 = nothing granted, 1 = data, 2 = fetch.
  task automatic access(input logic wd, input logic wi, input logic we,
                        input logic [31:0] daddr, input logic [31:0] iaddr,
                        input logic [31:0] wdat, input logic [31:0] adat,
                        input int lat, input logic never, output int who);
    logic        ed, ei, e_we;
    logic [31:0] e_addr, e_rd;
    int          e_busy, n;
    d_req = wd; if_req = wi; d_we = we;
    d_addr = daddr; if_addr = iaddr; d_wdata = wdat;
    ack_lat = lat; ack_never = never; ack_data = adat;
    #1;
    ed = wd && (!wi || m_streak < MAX_DSTREAK);
    ei = !ed && wi;
    chk("d_gnt", d_gnt, ed);
    chk("if_gnt", if_gnt, ei);
    if (ei || !wi) m_streak = 0;
    else if (ed && m_streak < MAX_DSTREAK) m_streak++;
    who = ed ? 1 : (ei ? 2 : 0);
    if (!ed && !ei) begin
      tick();
      return;
    end
    if (ed) m_wdata = wdat;
    e_addr = ed ? daddr : iaddr;
    e_we   = ed && we;
    e_busy = never ? TIMEOUT : lat;
    tick();
    chk("done_cleared", {if_done, d_done}, 0);
    n = 0;
    while (mem_req === 1'b1 && n < 64) begin
      n++;
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("busy_gnt", {d_gnt, if_gnt}, 0);
      tick();
    end
    chk("busy_len", n, e_busy);
    e_rd = (never || e_we) ? 32'h0 : adat;
    if (ed) m_d_rdata = e_rd;
    else m_if_rdata = e_rd;
    chk("d_done", d_done, ed);
    chk("if_done", if_done, ei);
    chk(ed ? "d_err" : "if_err", ed ? d_err : if_err, never);
    chk("d_rdata", d_rdata, m_d_rdata);
    chk("if_rdata", if_rdata, m_if_rdata);
  endtask

  initial begin
    int          who;
    int          lat;
    logic [31:0] r;
    int          exp_seq[10];
    exp_seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

    rst = 1'b1; if_req = 1'b1; if_addr = 32'h4; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h8; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

    // Reset: grants suppressed while rst is high, all registers at reset values.
    tick();
    chk("rst_gnt", {d_gnt, if_gnt}, 0);
    chk_reset_vals("rst");
    tick();
    rst = 1'b0; d_req = 1'b0; if_req = 1'b0;
    tick();
    chk_reset_vals("post_rst");

    // Single load, memory acks on the third mem_req cycle.
    access(1, 0, 0, 32'h10, 32'h0, 32'h0, 32'hDEADBEEF, 3, 0, who);
    chk("load_who", who, 1);
    chk("load_rdata", d_rdata, 32'hDEADBEEF);
    chk("load_err", d_err, 0);
    d_req = 1'b0;

    // Simultaneous requests: data first, fetch granted in the data done cycle.
    tick();
    access(1, 1, 0, 32'h100, 32'h200, 32'h0, 32'hA5A5_0001, 1, 0, who);
    chk("simul_first", who, 1);
    access(0, 1, 0, 32'h100, 32'h200, 32'h0, 32'hA5A5_0002, 1, 0, who);
    chk("simul_second", who, 2);
    chk("simul_if_rdata", if_rdata, 32'hA5A5_0002);

    // Starvation: both held high, fetch forced after four data grants.
    access(0, 0, 0, 0, 0, 0, 0, 1, 0, who);
    for (int k = 0; k < 10; k++) begin
      access(1, 1, 0, 32'h300 + k, 32'h400 + k, 32'h0, $urandom, 1, 0, who);
      chk("starve_seq", who, exp_seq[k]);
    end
    d_req = 1'b0; if_req = 1'b0;

    // Store completion returns zero data.
    tick();
    access(1, 0, 1, 32'h20, 32'h0, 32'h12345678, 32'hFFFF_FFFF, 2, 0, who);
    chk("store_rdata", d_rdata, 0);
    chk("store_err", d_err, 0);
    d_req = 1'b0;

    // Fetch timeout, then a stray late ack must do nothing.
    tick();
    access(0, 1, 0, 32'h0, 32'h40, 32'h0, 32'h1234, 1, 1, who);
    chk("to_err", if_err, 1);
    chk("to_rdata", if_rdata, 0);
    if_req = 1'b0;
    inject_ack = 1'b1;
    tick();
    tick();
    chk("late_ack_done", {if_done, d_done}, 0);
    chk("late_ack_req", mem_req, 0);

    // Ack on the last watchdog cycle completes normally.
    access(0, 1, 0, 32'h0, 32'h44, 32'h0, 32'hCAFE_F00D, TIMEOUT, 0, who);
    chk("ack16_err", if_err, 0);
    chk("ack16_rdata", if_rdata, 32'hCAFE_F00D);
    if_req = 1'b0;

    // Reset while a data access is outstanding.
    tick();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; ack_never = 1'b1;
    #1;
    chk("mid_gnt", d_gnt, 1);
    tick();
    tick();
    chk("mid_busy", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", {d_gnt, if_gnt}, 0);
    tick();
    rst = 1'b0; d_req = 1'b0;
    m_streak = 0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
    chk_reset_vals("mid_rst");
    inject_ack = 1'b1;
    tick();
    tick();
    chk("mid_late_done", {if_done, d_done}, 0);
    chk("mid_late_req", mem_req, 0);
    access(1, 0, 0, 32'h84, 32'h0, 32'h0, 32'h5555_AAAA, 2, 0, who);
    chk("mid_after_rdata", d_rdata, 32'h5555_AAAA);
    d_req = 1'b0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 60; i++) begin
      r   = $urandom;
      lat = $urandom_range(1, 5);
      access(r[0], r[1], r[2], $urandom, $urandom, $urandom, $urandom, lat,
             ($urandom_range(0, 7) == 0), who);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
